div_sequencer: RTL

//   Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, alongside the single-cycle ALU in EX.

---
 rtl/div_sequencer_pkg.sv | 29 ++
 rtl/div_sequencer_divu_iter.sv | 62 ++++++
 rtl/div_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared constants, FSM state type and small decode helper for the RV32M divide sequencer.
package div_sequencer_pkg;

    localparam int DIV_XLEN = 32;
    localparam int DIV_CNTW = 5;

    // funct3 encodings of the RV32M divide group
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Instruction fields that identify an M-extension op in EX
    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    // True when the op returns the remainder rather than the quotient
    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/div_sequencer_divu_iter.sv
// Unsigned radix-2 restoring divide datapath: one shift/trial-subtract step per enabled cycle.
module div_sequencer_divu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   trial_s;

    // Next-state: load fresh operands, or shift {rem,quo} left and keep the difference when it does not borrow.
    // Since rem < divisor, the trial difference fits in XLEN bits exactly when the top bit is clear.
    always_comb begin
        shifted_s = {rem_q, quo_q[XLEN-1]};
        trial_s   = shifted_s - {1'b0, dvs_q};
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!trial_s[XLEN]) begin
                rem_d = trial_s[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted_s[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            rem_d = rem_q;
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: FSM, iteration counter, special cases, sign fixup and result register.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = DIV_XLEN,
    parameter int CNTW = DIV_CNTW
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] srca_i,
    input  logic [XLEN-1:0] srcb_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            signed_q, signed_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept_s;
    logic            signed_in_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s;
    logic            load_s, step_s;
    logic [XLEN-1:0] quo_s, rem_s;
    logic [XLEN-1:0] quo_fix_s, rem_fix_s;

    div_sequencer_divu_iter #(.XLEN(XLEN)) u_iter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load_s),
        .step_i     (step_s),
        .dividend_i (abs_a_s),
        .divisor_i  (abs_b_s),
        .quo_o      (quo_s),
        .rem_o      (rem_s)
    );

    // Next-state, datapath control and result selection; flush always returns to IDLE without touching result
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        signed_d    = signed_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        result_d    = result_q;
        load_s      = 1'b0;
        step_s      = 1'b0;
        accept_s    = start_i & ~flush_i;
        signed_in_s = ~funct3_i[0];
        // Magnitudes; the most negative value maps onto itself and is treated as unsigned
        abs_a_s     = (signed_in_s & srca_i[XLEN-1]) ? (~srca_i + XLEN'(1)) : srca_i;
        abs_b_s     = (signed_in_s & srcb_i[XLEN-1]) ? (~srcb_i + XLEN'(1)) : srcb_i;
        quo_fix_s   = (signed_q & (sign_a_q ^ sign_b_q)) ? (~quo_s + XLEN'(1)) : quo_s;
        rem_fix_s   = (signed_q & sign_a_q) ? (~rem_s + XLEN'(1)) : rem_s;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    f3_d     = funct3_i;
                    signed_d = signed_in_s;
                    sign_a_d = signed_in_s & srca_i[XLEN-1];
                    sign_b_d = signed_in_s & srcb_i[XLEN-1];
                    if (srcb_i == '0) begin
                        result_d = is_rem_op(funct3_i) ? srca_i : '1;
                        state_d  = S_DONE;
                    end else if (signed_in_s && (srca_i == MIN_NEG) && (srcb_i == '1)) begin
                        result_d = is_rem_op(funct3_i) ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        load_s  = 1'b1;
                        cnt_d   = CNTW'(XLEN-1);
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = is_rem_op(f3_q) ? rem_fix_s : quo_fix_s;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign stall_o  = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_ITER) | (state_q == S_FIX);
    assign result_o = result_q;

endmodule
